// File: rtl/vga_rx.sv
// VGA capture front end: measures HS/VS timing, locks after clean frames, emits frame-buffer writes.
// Optional build macro VGA_RX_ERR_CNT_EN adds a saturating timing-error counter on err_cnt_o.
module vga_rx #(
  parameter int HSYNC_BITS  = 11,
  parameter int VSYNC_BITS  = 11,
  parameter int HD          = 1280,
  parameter int HF          = 48,
  parameter int HR          = 112,
  parameter int HB          = 248,
  parameter int VD          = 1024,
  parameter int VF          = 1,
  parameter int VR          = 3,
  parameter int VB          = 38,
  parameter int LOCK_FRAMES = 2
) (
  input  logic                  clk,
  input  logic                  arstn,
  input  logic                  VGA_HS,
  input  logic                  VGA_VS,
  input  logic [11:0]           RGB,
  output logic                  we_o,
  output logic [HSYNC_BITS-1:0] addr_x_o,
  output logic [VSYNC_BITS-1:0] addr_y_o,
  output logic [1:0]            color_o,
  output logic                  locked_o,
  output logic                  frame_o,
  output logic                  err_o,
  output logic [7:0]            err_cnt_o
);

  localparam int HMAX = HD + HF + HR + HB - 1;
  localparam int VMAX = VD + VF + VR + VB - 1;
  localparam int GW   = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

  localparam logic [HSYNC_BITS-1:0] H_MAX   = HSYNC_BITS'(HMAX);
  localparam logic [HSYNC_BITS-1:0] H_OVER  = HSYNC_BITS'(HMAX + 1);
  localparam logic [HSYNC_BITS-1:0] X_START = HSYNC_BITS'(HR + HB);
  localparam logic [HSYNC_BITS-1:0] X_END   = HSYNC_BITS'(HR + HB + HD);
  localparam logic [VSYNC_BITS-1:0] V_MAX   = VSYNC_BITS'(VMAX);
  localparam logic [VSYNC_BITS-1:0] V_OVER  = VSYNC_BITS'(VMAX + 1);
  localparam logic [VSYNC_BITS-1:0] Y_START = VSYNC_BITS'(VR + VB);
  localparam logic [VSYNC_BITS-1:0] Y_END   = VSYNC_BITS'(VR + VB + VD);
  localparam logic [GW-1:0]         G_LOCK  = GW'(LOCK_FRAMES);

  localparam logic [1:0] BLACK = 2'd0;
  localparam logic [1:0] WHITE = 2'd1;
  localparam logic [1:0] BLUE  = 2'd2;
  localparam logic [1:0] GREEN = 2'd3;

  typedef enum logic [1:0] {SEARCH, ACQUIRE, LOCKED} state_t;

  state_t                  state_reg, state_next;
  logic [GW-1:0]           good_reg, good_next;
  logic                    hs1_reg, vs1_reg, hs2_reg, vs2_reg;
  logic [2:0]              rgb1_reg;
  logic [HSYNC_BITS-1:0]   hcnt_reg, hcnt_next;
  logic [VSYNC_BITS-1:0]   vcnt_reg, vcnt_next;
  logic                    hs_rise, vs_rise, viol, active;
  logic                    we_next, err_next, frame_next;
  logic [1:0]              color_next;

  // Only the MSB of each colour nibble feeds the quantiser.
  logic unused_rgb;
  assign unused_rgb = ^{RGB[10:8], RGB[6:4], RGB[2:0]};

  always_comb begin
    hs_rise = hs1_reg & ~hs2_reg;
    vs_rise = vs1_reg & ~vs2_reg;

    if (hs_rise)
      hcnt_next = '0;
    else if (&hcnt_reg)
      hcnt_next = hcnt_reg;
    else
      hcnt_next = hcnt_reg + 1'b1;

    vcnt_next = vcnt_reg;
    if (hs_rise) begin
      if (vs_rise)
        vcnt_next = '0;
      else if (!(&vcnt_reg))
        vcnt_next = vcnt_reg + 1'b1;
    end

    // Vertical overrun is flagged on the first clock of the line that pushed vcnt past VMAX.
    viol = (hs_rise && hcnt_reg != H_MAX) || (hcnt_reg == H_OVER) ||
           (vs_rise && vcnt_reg != V_MAX) || (vcnt_reg == V_OVER && hcnt_reg == '0);

    // hcnt_next/vcnt_next are the coordinates of the sample currently held in s1.
    active = (hcnt_next >= X_START) && (hcnt_next < X_END) &&
             (vcnt_next >= Y_START) && (vcnt_next < Y_END);
  end

  always_comb begin
    color_next = BLACK;
    if (rgb1_reg[2] && rgb1_reg[1] && rgb1_reg[0])
      color_next = WHITE;
    else if (rgb1_reg[2] && !rgb1_reg[1])
      color_next = BLUE;
    else if (rgb1_reg[1] && !rgb1_reg[2])
      color_next = GREEN;
  end

  always_comb begin
    state_next = state_reg;
    good_next  = good_reg;
    err_next   = 1'b0;
    frame_next = 1'b0;
    case (state_reg)
      SEARCH: begin
        good_next = '0;
        if (vs_rise && hs_rise)
          state_next = ACQUIRE;
      end
      ACQUIRE: begin
        if (viol) begin
          err_next   = 1'b1;
          state_next = SEARCH;
          good_next  = '0;
        end else if (vs_rise) begin
          good_next = good_reg + 1'b1;
          if (good_reg + 1'b1 == G_LOCK)
            state_next = LOCKED;
        end
      end
      LOCKED: begin
        if (viol) begin
          err_next   = 1'b1;
          state_next = SEARCH;
          good_next  = '0;
        end else if (vs_rise) begin
          frame_next = 1'b1;
        end
      end
      default: begin
        state_next = SEARCH;
        good_next  = '0;
      end
    endcase
    we_next = (state_reg == LOCKED) && active && !viol;
  end

  always_ff @(posedge clk) begin
    if (!arstn) begin
      state_reg <= SEARCH;
      good_reg  <= '0;
      hs1_reg   <= 1'b0;
      vs1_reg   <= 1'b0;
      hs2_reg   <= 1'b0;
      vs2_reg   <= 1'b0;
      rgb1_reg  <= '0;
      hcnt_reg  <= '0;
      vcnt_reg  <= '0;
      we_o      <= 1'b0;
      addr_x_o  <= '0;
      addr_y_o  <= '0;
      color_o   <= BLACK;
      locked_o  <= 1'b0;
      frame_o   <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      state_reg <= state_next;
      good_reg  <= good_next;
      hs1_reg   <= VGA_HS;
      vs1_reg   <= VGA_VS;
      hs2_reg   <= hs1_reg;
      vs2_reg   <= vs1_reg;
      rgb1_reg  <= {RGB[11], RGB[7], RGB[3]};
      hcnt_reg  <= hcnt_next;
      vcnt_reg  <= vcnt_next;
      we_o      <= we_next;
      if (we_next) begin
        addr_x_o <= hcnt_next - X_START;
        addr_y_o <= vcnt_next - Y_START;
        color_o  <= color_next;
      end
      locked_o  <= (state_next == LOCKED);
      frame_o   <= frame_next;
      err_o     <= err_next;
    end
  end

`ifdef VGA_RX_ERR_CNT_EN
  logic [7:0] err_cnt_reg;
  always_ff @(posedge clk) begin
    if (!arstn)
      err_cnt_reg <= 8'd0;
    else if (err_next && err_cnt_reg != 8'hFF)
      err_cnt_reg <= err_cnt_reg + 8'd1;
  end
  assign err_cnt_o = err_cnt_reg;
`else
  assign err_cnt_o = 8'd0;
`endif

endmodule

// File: tb/tb_vga_rx.sv
// Scoreboard bench for vga_rx on a 14x7 toy raster (8x4 visible, lock after 2 frames).
module tb_vga_rx;
  localparam int HTOT = 14;
  localparam int VTOT = 7;

  logic        clk = 1'b0;
  logic        arstn = 1'b0;
  logic        hs = 1'b0;
  logic        vs = 1'b0;
  logic [11:0] rgb = 12'h000;
  logic        we;
  logic [10:0] ax;
  logic [10:0] ay;
  logic [1:0]  col;
  logic        locked, frame, err;
  logic [7:0]  err_cnt;

  vga_rx #(
    .HSYNC_BITS(11), .VSYNC_BITS(11),
    .HD(8), .HF(2), .HR(2), .HB(2),
    .VD(4), .VF(1), .VR(1), .VB(1),
    .LOCK_FRAMES(2)
  ) dut (
    .clk(clk), .arstn(arstn), .VGA_HS(hs), .VGA_VS(vs), .RGB(rgb),
    .we_o(we), .addr_x_o(ax), .addr_y_o(ay), .color_o(col),
    .locked_o(locked), .frame_o(frame), .err_o(err), .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int x;
    int y;
    int c;
    int t;
  } pix_t;

  pix_t pix_q[$];
  int   frm_q[$];
  int   err_q[$];
  int   n_chk = 0;
  int   n_fail = 0;

  logic [11:0] rgb_tab [6] = '{12'hF00, 12'h0F0, 12'hFFF, 12'h123, 12'h8F0, 12'h088};
  int          col_tab [6] = '{2, 3, 1, 0, 0, 3};

`ifdef VGA_RX_ERR_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_we"}, int'(we), 0);
    chk({tag, "_x"}, int'(ax), 0);
    chk({tag, "_y"}, int'(ay), 0);
    chk({tag, "_color"}, int'(col), 0);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_frame"}, int'(frame), 0);
    chk({tag, "_err"}, int'(err), 0);
    chk({tag, "_err_cnt"}, int'(err_cnt), 0);
  endtask

  task automatic pin(input logic h, input logic v, input logic [11:0] d);
    @(negedge clk);
    arstn = 1'b1;
    hs = h;
    vs = v;
    rgb = d;
  endtask

  // One raster frame; a disruption line index of -1 means none.
  task automatic drive_frame(input int f, input bit wr, input bit frm,
                             input int short_l, input int long_l, input int rst_l);
    bit          w;
    int          len, x, y, idx;
    bit          act;
    logic [11:0] d;
    pix_t        p;
    w = wr;
    for (int l = 0; l < VTOT; l++) begin
      len = (l == short_l) ? 13 : ((l == long_l) ? 22 : HTOT);
      for (int t = 0; t < len; t++) begin
        act = (l >= 2 && l < 6 && t >= 4 && t < 12);
        x = t - 4;
        y = l - 2;
        idx = act ? (x + y + f) % 6 : (t + l) % 6;
        d = rgb_tab[idx];
        if (l == rst_l && t == 3) begin
          @(negedge clk);
          arstn = 1'b0;
          hs = 1'b0;
          vs = (l == 0);
          rgb = d;
          w = 1'b0;
          @(posedge clk);
          #1;
          check_idle("mid_reset");
        end else begin
          pin(t < 2, l == 0, d);
        end
        if (l == 0 && t == 0 && frm) frm_q.push_back(cyc + 2);
        if (l > 0 && t == 0 && l - 1 == short_l) begin
          err_q.push_back(cyc + 2);
          w = 1'b0;
        end
        if (l == long_l && t == 15) begin
          err_q.push_back(cyc + 2);
          w = 1'b0;
        end
        if (act && w) begin
          p.x = x;
          p.y = y;
          p.c = col_tab[idx];
          p.t = cyc + 2;
          pix_q.push_back(p);
        end
        if (t == 0 && l == 1) chk("locked_early", int'(locked), int'(wr));
        if (t == 0 && l == 6) chk("locked_late", int'(locked), int'(w));
      end
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a write, frame or error pulse.
  initial begin
    pix_t e;
    int   ft;
    forever begin
      @(posedge clk);
      #1;
      if (we === 1'b1) begin
        n_chk++;
        if (pix_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_we: got write x=%0d y=%0d c=%0d at cycle %0d, expected none",
                   ax, ay, col, cyc);
        end else begin
          e = pix_q.pop_front();
          if (int'(ax) != e.x || int'(ay) != e.y || int'(col) != e.c || cyc != e.t) begin
            n_fail++;
            $display("FAIL pixel: got x=%0d y=%0d c=%0d cyc=%0d, expected x=%0d y=%0d c=%0d cyc=%0d",
                     ax, ay, col, cyc, e.x, e.y, e.c, e.t);
          end
        end
      end
      if (frame === 1'b1) begin
        n_chk++;
        if (frm_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_frame: got frame_o at cycle %0d, expected none", cyc);
        end else begin
          ft = frm_q.pop_front();
          if (cyc != ft) begin
            n_fail++;
            $display("FAIL frame_cycle: got %0d, expected %0d", cyc, ft);
          end
        end
      end
      if (err === 1'b1) begin
        n_chk++;
        if (err_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_err: got err_o at cycle %0d, expected none", cyc);
        end else begin
          ft = err_q.pop_front();
          if (cyc != ft) begin
            n_fail++;
            $display("FAIL err_cycle: got %0d, expected %0d", cyc, ft);
          end
        end
        chk("locked_at_err", int'(locked), 0);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    arstn = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_idle("reset");
    repeat (3) pin(1'b0, 1'b0, 12'h000);

    // Acquire and lock, then steady locked frames.
    drive_frame(1, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(2, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(3, 1'b1, 1'b0, -1, -1, -1);
    for (int f = 4; f <= 7; f++) drive_frame(f, 1'b1, 1'b1, -1, -1, -1);

    // Short line, then relock.
    drive_frame(8, 1'b1, 1'b1, 3, -1, -1);
    chk("err_cnt_after_short", int'(err_cnt), CNT_EN ? 1 : 0);
    drive_frame(9, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(10, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(11, 1'b1, 1'b0, -1, -1, -1);

    // HS held low 20 clocks, then relock.
    drive_frame(12, 1'b1, 1'b1, -1, 2, -1);
    chk("err_cnt_after_long", int'(err_cnt), CNT_EN ? 2 : 0);
    drive_frame(13, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(14, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(15, 1'b1, 1'b0, -1, -1, -1);

    // One-cycle reset mid-line, then relock.
    drive_frame(16, 1'b1, 1'b1, -1, -1, 3);
    drive_frame(17, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(18, 1'b0, 1'b0, -1, -1, -1);
    drive_frame(19, 1'b1, 1'b0, -1, -1, -1);
    drive_frame(20, 1'b1, 1'b1, -1, -1, -1);

    @(negedge clk);
    arstn = 1'b0;
    hs = 1'b0;
    vs = 1'b0;
    @(posedge clk);
    #1;
    check_idle("reset2");

    // 300 violations: each VS/HS edge pair enters ACQUIRE then breaks it 4 clocks later.
    for (int i = 0; i < 300; i++) begin
      pin(1'b1, 1'b1, 12'h000);
      pin(1'b1, 1'b1, 12'h000);
      pin(1'b0, 1'b0, 12'h000);
      pin(1'b0, 1'b0, 12'h000);
      pin(1'b1, 1'b1, 12'h000);
      err_q.push_back(cyc + 2);
      pin(1'b1, 1'b1, 12'h000);
      pin(1'b0, 1'b0, 12'h000);
      pin(1'b0, 1'b0, 12'h000);
    end
    repeat (10) pin(1'b0, 1'b0, 12'h000);
    chk("err_cnt_saturated", int'(err_cnt), CNT_EN ? 255 : 0);
    chk("pix_queue_empty", pix_q.size(), 0);
    chk("frame_queue_empty", frm_q.size(), 0);
    chk("err_queue_empty", err_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/vga_rx.md
VGA_RX -- requirements
Module: vga_rx

Interface
REQ-001 SHALL have parameter HSYNC_BITS, default 11, meaning horizontal counter/address width.
REQ-002 SHALL have parameter VSYNC_BITS, default 11, meaning vertical counter/address width.
REQ-003 SHALL have parameters HD/HF/HR/HB, defaults 1280/48/112/248, meaning horizontal display/front porch/sync/back porch in clocks; HMAX = HD+HF+HR+HB-1.
REQ-004 SHALL have parameters VD/VF/VR/VB, defaults 1024/1/3/38, meaning vertical display/front porch/sync/back porch in lines; VMAX = VD+VF+VR+VB-1.
REQ-005 SHALL have parameter LOCK_FRAMES, default 2, meaning consecutive good frames required for lock.
REQ-006 clk  input  1  pixel clock; the only clock.
REQ-007 arstn  input  1  reset; synchronous, active-low.
REQ-008 VGA_HS  input  1  horizontal sync, active-high.
REQ-009 VGA_VS  input  1  vertical sync, active-high.
REQ-010 RGB  input  12  pixel colour; [11:8] blue, [7:4] green, [3:0] red.
REQ-011 we_o  output  1  frame-buffer write strobe, one per captured pixel.
REQ-012 addr_x_o  output  HSYNC_BITS  pixel column, 0..HD-1.
REQ-013 addr_y_o  output  VSYNC_BITS  pixel row, 0..VD-1.
REQ-014 color_o  output  2  quantised colour: BLACK=0, WHITE=1, BLUE=2, GREEN=3.
REQ-015 locked_o  output  1  high while state is LOCKED.
REQ-016 frame_o  output  1  one-cycle pulse at each VS rising edge while LOCKED.
REQ-017 err_o  output  1  one-cycle pulse on any timing violation outside SEARCH.
REQ-018 err_cnt_o  output  8  timing-error count (see Configuration).

Function
REQ-019 VGA_HS, VGA_VS, RGB SHALL be registered once (stage s1); a second register s2 holds previous HS/VS; rising edge = s1 & !s2.
REQ-020 On HS rising edge hcnt SHALL load 0, else increment, saturating at all-ones.
REQ-021 On HS rising edge, vcnt SHALL load 0 if VS rising edge in same cycle, else increment, saturating at all-ones.
REQ-022 Pixel active SHALL be hcnt in [HR+HB, HR+HB+HD) and vcnt in [VR+VB, VR+VB+VD); addr_x_o = hcnt-(HR+HB), addr_y_o = vcnt-(VR+VB).
REQ-023 Quantisation on s1 RGB: b=RGB[11], g=RGB[7], r=RGB[3]; b&g&r -> WHITE; b&!g -> BLUE; g&!b -> GREEN; otherwise BLACK.
REQ-024 Latency: pixel on pins in cycle N SHALL produce we_o/addr/color_o in cycle N+2, all outputs registered.
REQ-025 Timing violation = HS rising edge with hcnt != HMAX, or hcnt == HMAX+1 reached without HS edge, or VS rising edge with vcnt != VMAX, or vcnt exceeds VMAX.
REQ-026 States: SEARCH, ACQUIRE, LOCKED.
REQ-027 SEARCH -> ACQUIRE on first VS rising edge (coincident with HS rising edge); violations ignored in SEARCH.
REQ-028 ACQUIRE: good-frame counter increments on each violation-free VS rising edge; -> LOCKED when it reaches LOCK_FRAMES.
REQ-029 Any violation in ACQUIRE or LOCKED SHALL pulse err_o and go to SEARCH next cycle, clearing good-frame counter.
REQ-030 we_o SHALL assert only in LOCKED on active pixels; a violation cycle SHALL suppress we_o in that same output cycle.
REQ-031 VS rising edge and violation in the same cycle: violation wins, no frame_o.

Reset
REQ-032 While arstn low at a clk edge: state SEARCH, counters 0, s1/s2 0, we_o/frame_o/err_o/locked_o 0, addrs 0, color_o BLACK, err_cnt_o 0.
REQ-033 Reset asserted mid-frame SHALL abort capture with no further we_o until relock.

Configuration
REQ-034 Macro VGA_RX_ERR_CNT_EN defined: err_cnt_o increments on each err_o pulse, saturating at 255, cleared only by reset.
REQ-035 Macro VGA_RX_ERR_CNT_EN undefined: err_cnt_o tied to 0, no counter logic built.

Verification (HD=8,HF=2,HR=2,HB=2,VD=4,VF=1,VR=1,VB=1,LOCK_FRAMES=2; HMAX=13,VMAX=6)
REQ-036 Reset then 3 ideal frames -> locked_o rises at start of frame 3; frame 3 gives exactly 32 we_o, x 0..7, y 0..3.
REQ-037 Locked, RGB=12'hF00 / 12'h0F0 / 12'hFFF / 12'h123 on pixel (0,0) -> color_o 2 / 3 / 1 / 0 two cycles later.
REQ-038 Locked, one line shortened to 13 clocks -> err_o pulse, locked_o 0 next cycle, no we_o until two good frames pass.
REQ-039 Locked, HS held low 20 clocks -> err_o at hcnt=14, state SEARCH.
REQ-040 Locked, arstn low one cycle mid-line -> all outputs 0 next cycle, relock after 2 further frames.
REQ-041 With VGA_RX_ERR_CNT_EN, 300 induced violations -> err_cnt_o = 255; without macro -> err_cnt_o = 0.
